// File: rtl/priority_decoder.sv
// Buffered one-hot decoder: accepts encoded positions over valid/ready, queues them
// pre-decoded in a small FIFO, and presents them through a registered output stage.
module priority_decoder #(
    parameter int N     = 4,
    parameter int POS_W = $clog2(N),
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [POS_W-1:0]              pos,
    input  logic                          none,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  onehot,
    output logic [$clog2(DEPTH+2)-1:0]    level,
    output logic                          err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int LVL_W = $clog2(DEPTH+2);

    logic [N-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             out_valid_reg;
    logic [N-1:0]     onehot_reg;
    logic             err_reg;
    logic [LVL_W-1:0] level_reg;

    logic [N-1:0]     decoded;
    logic             illegal;
    logic             accept;
    logic             out_free;
    logic             pop;
    logic             fall;
    logic             push;
    logic [CNT_W-1:0] count_next;
    logic             out_valid_next;
    logic [LVL_W-1:0] level_next;

    // Out-of-range positions match no bit, so they decode to all zero naturally.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign decoded[gi] = !none && (pos == POS_W'(gi));
        end
    endgenerate

    assign illegal  = !none && ({1'b0, pos} >= (POS_W+1)'(N));
    assign in_ready = (count_reg < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_reg || out_ready;
    assign pop      = out_free && (count_reg != '0);
    // Bypass only when the FIFO is empty, which keeps strict arrival order.
    assign fall     = out_free && (count_reg == '0) && accept;
    assign push     = accept && !fall;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
        out_valid_next = out_free ? (pop || fall) : out_valid_reg;
        level_next     = LVL_W'(count_next) + LVL_W'(out_valid_next);
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_reg] <= decoded;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            onehot_reg    <= '0;
            err_reg       <= 1'b0;
            level_reg     <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            if (out_free) begin
                out_valid_reg <= pop || fall;
                if (pop) begin
                    onehot_reg <= mem[rd_ptr_reg];
                end else if (fall) begin
                    onehot_reg <= decoded;
                end
            end
            if (accept && illegal) begin
                err_reg <= 1'b1;
            end
            level_reg <= level_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign onehot    = onehot_reg;
    assign err       = err_reg;
    assign level     = level_reg;

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder: an N=4 instance checked against a queue model,
// plus an N=6 instance exercising illegal positions and the sticky error flag.
module tb_priority_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, none, out_valid, out_ready, err;
    logic [1:0] pos;
    logic [3:0] onehot;
    logic [2:0] level;

    logic       b_in_valid, b_in_ready, b_none, b_out_valid, b_out_ready, b_err;
    logic [2:0] b_pos;
    logic [5:0] b_onehot;
    logic [2:0] b_level;

    int n_cmp = 0;
    int n_err = 0;
    int max_level = 0;
    int pops = 0;
    logic [3:0] exp_q [$];
    logic exp_err;

    always #5 clk = ~clk;

    priority_decoder #(.N(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pos(pos), .none(none), .out_valid(out_valid), .out_ready(out_ready),
        .onehot(onehot), .level(level), .err(err)
    );

    priority_decoder #(.N(6), .DEPTH(4)) dut6 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pos(b_pos), .none(b_none), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .onehot(b_onehot), .level(b_level), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [1:0] p, input logic nn);
        logic [3:0] v;
        v = 4'b0001 << p;
        return nn ? 4'b0000 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat and holds it until accepted; returns the number of edges waited.
    task automatic send(input logic [1:0] p, input logic nn, output int cyc);
        logic acc;
        acc = 1'b0;
        cyc = 0;
        in_valid = 1'b1;
        pos = p;
        none = nn;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            cyc++;
            if (acc) break;
        end
        in_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    // Scoreboard monitor: evaluates the handshakes that the coming edge will perform.
    always @(negedge clk) begin
        int fifo_cnt;
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            fifo_cnt = exp_q.size() - ((exp_q.size() != 0) ? 1 : 0);
            if (int'(level) > max_level) max_level = int'(level);
            check("level", level, exp_q.size());
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, fifo_cnt < 4);
            check("err", err, exp_err);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", exp_q.size(), 1);
                end else begin
                    check("onehot_order", onehot, exp_q[0]);
                    $display("pop %0d: onehot=%b expected=%b", pops, onehot, exp_q[0]);
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(pos, none));
                $display("push: pos=%0d none=%0b", pos, none);
            end
        end
    end

    initial begin
        int cyc;
        int sent;
        logic [1:0] seq [6];
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0; seq[5] = 2'd1;

        rst = 1'b1; in_valid = 1'b0; pos = '0; none = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_pos = '0; b_none = 1'b0; b_out_ready = 1'b1;
        exp_err = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_onehot", onehot, 0);
        check("rst_level", level, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);

        // single beat through the bypass path
        out_ready = 1'b1;
        send(2'd2, 1'b0, cyc);
        check("ft_onehot", onehot, 4'b0100);
        check("ft_valid", out_valid, 1);
        step();
        check("ft_valid_drop", out_valid, 0);

        // fill with backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(seq[i], 1'b0, cyc);
        check("fill_level", level, 5);
        check("fill_in_ready", in_ready, 0);
        check("fill_head", onehot, 4'b0001);
        in_valid = 1'b1; pos = seq[5];
        step(); step();
        check("hold_in_ready", in_ready, 0);
        check("hold_onehot", onehot, 4'b0001);
        check("hold_level", level, 5);
        out_ready = 1'b1;
        send(seq[5], 1'b0, cyc);
        check("sixth_accept_cycles", cyc, 2);
        repeat (7) step();
        check("fill_drained", out_valid, 0);
        check("fill_pops", pops, 7);

        // random streaming with wrap
        sent = 0;
        for (int i = 0; i < 2000 && sent < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            pos = 2'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, 20);
        for (int i = 0; i < 20 && out_valid; i++) step();
        step();
        check("stream_drained", out_valid, 0);
        check("stream_queue_empty", exp_q.size(), 0);
        check("stream_level_max", max_level <= 5, 1);

        // none flag
        send(2'd3, 1'b1, cyc);
        check("none_onehot", onehot, 0);
        check("none_valid", out_valid, 1);
        check("none_err", err, 0);
        step();

        // illegal position on the N=6 instance
        b_in_valid = 1'b1; b_pos = 3'd7; b_none = 1'b0;
        step();
        b_in_valid = 1'b0;
        check("n6_illegal_onehot", b_onehot, 0);
        check("n6_illegal_valid", b_out_valid, 1);
        check("n6_err_set", b_err, 1);
        b_in_valid = 1'b1; b_pos = 3'd5;
        step();
        b_in_valid = 1'b0;
        check("n6_pos5_onehot", b_onehot, 6'b100000);
        check("n6_err_sticky", b_err, 1);
        step();
        check("n6_err_sticky2", b_err, 1);

        // reset while holding beats
        out_ready = 1'b0;
        send(2'd0, 1'b0, cyc);
        send(2'd3, 1'b0, cyc);
        send(2'd2, 1'b0, cyc);
        check("mid_level", level, 3);
        check("mid_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_onehot", onehot, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("n6_err_cleared", b_err, 0);
        out_ready = 1'b1;
        send(2'd1, 1'b0, cyc);
        check("post_rst_onehot", onehot, 4'b0010);
        check("post_rst_level", level, 1);
        repeat (3) step();
        check("post_rst_drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
